// File: rtl/req_agent.sv
// Client-side request agent: buffers upstream commands, requests the arbiter while
// anything is buffered, issues one command per grant and flags starvation.
module req_agent #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [DATA_W-1:0]          cmd_data,
    output logic                       req,
    input  logic                       grant,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] pending,
    output logic                       starve
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, STARVE} state_t;

    state_t              state, state_next;
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count, count_next;
    logic [TW-1:0]       wait_cnt, wait_next;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                push, pop;

    assign cmd_ready = (count < CW'(DEPTH));
    assign req       = (count != '0);
    assign pending   = count;
    assign push      = cmd_valid && cmd_ready;
    // A grant only counts while we are actually requesting.
    assign pop       = req && grant;

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + CW'(1);
        else if (pop && !push)
            count_next = count - CW'(1);
    end

    always_comb begin
        wait_next = wait_cnt;
        if (!req || pop)
            wait_next = '0;
        else if (wait_cnt != TW'(TIMEOUT))
            wait_next = wait_cnt + TW'(1);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (push) state_next = WAIT;
            WAIT:    if (count_next == '0)
                         state_next = IDLE;
                     else if (wait_next == TW'(TIMEOUT))
                         state_next = STARVE;
            STARVE:  if (pop) state_next = (count_next == '0) ? IDLE : WAIT;
            default: state_next = IDLE;
        endcase
    end

    // Payload storage carries no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= cmd_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            wait_cnt  <= '0;
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            starve    <= 1'b0;
        end else begin
            count     <= count_next;
            wait_cnt  <= wait_next;
            state     <= state_next;
            starve    <= (state_next == STARVE);
            out_valid <= pop;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                out_data <= mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_req_agent.sv
// Scoreboard bench for req_agent: a queue-based reference model predicts issued
// commands and status; a separate monitor checks every out_valid pulse.
module tb_req_agent;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              req;
    logic              grant = 1'b0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        pending;
    logic              starve;

    req_agent #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .req(req), .grant(grant),
        .out_valid(out_valid), .out_data(out_data),
        .pending(pending), .starve(starve)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: buffered commands, expected issues, consecutive unserved cycles.
    logic [DATA_W-1:0] model_q[$];
    logic [DATA_W-1:0] exp_q[$];
    int                unserved = 0;
    bit                exp_pulse = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every issued command must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fails++;
                $display("FAIL spurious_issue: got data %0h expected no issue at %0t", out_data, $time);
            end else begin
                check("issue_data", int'(out_data), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_status(input string tag);
        check({tag, "_pending"}, int'(pending), model_q.size());
        check({tag, "_req"}, int'(req), int'(model_q.size() != 0));
        check({tag, "_ready"}, int'(cmd_ready), int'(model_q.size() < DEPTH));
        check({tag, "_starve"}, int'(starve), int'(unserved >= TIMEOUT));
        check({tag, "_out_valid"}, int'(out_valid), int'(exp_pulse));
    endtask

    // One clock: drive inputs, predict the edge, then check at the following negedge.
    task automatic cycle(input bit v, input logic [DATA_W-1:0] d, input bit g, input string tag);
        bit do_pop, do_push, was_req;
        cmd_valid = v;
        cmd_data  = d;
        grant     = g;
        was_req   = (model_q.size() != 0);
        do_pop    = was_req && g;
        do_push   = v && (model_q.size() < DEPTH);
        @(posedge clk);
        if (do_pop) exp_q.push_back(model_q.pop_front());
        if (do_push) model_q.push_back(d);
        if (!was_req || do_pop) unserved = 0;
        else unserved++;
        exp_pulse = do_pop;
        @(negedge clk);
        check_status(tag);
        $display("cycle %-8s v=%0d d=%02h g=%0d | pend=%0d req=%0d rdy=%0d ov=%0d od=%02h starve=%0d",
                 tag, v, d, g, pending, req, cmd_ready, out_valid, out_data, starve);
    endtask

    task automatic reset_model();
        model_q.delete();
        exp_q.delete();
        unserved  = 0;
        exp_pulse = 0;
    endtask

    initial begin
        logic [DATA_W-1:0] vals [4];
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;

        #12;
        check("rst_req", int'(req), 0);
        check("rst_pending", int'(pending), 0);
        check("rst_ready", int'(cmd_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_starve", int'(starve), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single push, no grant.
        cycle(1, 8'hA1, 0, "push_a1");
        cycle(0, 8'h00, 1, "drain");

        // Four pushes then four grants.
        for (int i = 0; i < 4; i++) cycle(1, vals[i], 0, "fill");
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, "grant");

        // Full buffer with cmd_valid held and a single grant.
        for (int i = 0; i < 4; i++) cycle(1, 8'h50 + 8'(i), 0, "fill4");
        cycle(1, 8'h60, 1, "full_pop");
        cycle(1, 8'h61, 0, "refill");
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, "drain4");

        // Starvation after TIMEOUT unserved cycles, cleared by a grant.
        cycle(1, 8'h77, 0, "push_st");
        for (int i = 0; i < TIMEOUT + 2; i++) cycle(0, 8'h00, 0, "starve");
        cycle(0, 8'h00, 1, "st_grant");
        cycle(0, 8'h00, 0, "st_after");

        // Grant with nothing buffered.
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, "empty_g");

        // Mid-operation reset with three entries buffered, one issue in flight.
        for (int i = 0; i < 3; i++) cycle(1, 8'hC0 + 8'(i), 0, "pre_rst");
        cycle(0, 8'h00, 1, "pre_rst_g");
        cycle(1, 8'hC9, 0, "pre_rst2");
        cmd_valid = 1'b0;
        grant     = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        reset_model();
        check("mid_rst_req", int'(req), 0);
        check("mid_rst_pending", int'(pending), 0);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_ready", int'(cmd_ready), 1);
        check("mid_rst_starve", int'(starve), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, "post_rst");

        // Randomized traffic; the first phase grants rarely to provoke starvation.
        for (int i = 0; i < 400; i++) begin
            bit v, g;
            v = ($urandom_range(0, 1) == 1);
            if (i < 150) g = ($urandom_range(0, 19) == 0);
            else g = ($urandom_range(0, 2) != 0);
            cycle(v, 8'($urandom), g, "rand");
        end
        for (int i = 0; i < DEPTH + 1; i++) cycle(0, 8'h00, 1, "final");

        check("leftover_issues", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/req_agent.md
REQ_AGENT -- requirements
Module: req_agent

Interface
REQ-001 Parameter DATA_W, default 8, command payload width in bits.
REQ-002 Parameter DEPTH, default 4, command buffer entries; power of two, >= 2.
REQ-003 Parameter TIMEOUT, default 15, wait cycles before starvation is flagged; >= 1.
REQ-004 Port clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port cmd_valid  input  1  upstream command offered.
REQ-007 Port cmd_ready  output  1  agent can accept a command this cycle.
REQ-008 Port cmd_data  input  DATA_W  command payload.
REQ-009 Port req  output  1  request bit to this client's arbiter req input.
REQ-010 Port grant  input  1  this client's bit of the arbiter one-hot grant vector.
REQ-011 Port out_valid  output  1  one-cycle pulse: granted command issued.
REQ-012 Port out_data  output  DATA_W  issued command payload, valid with out_valid.
REQ-013 Port pending  output  $clog2(DEPTH+1)  buffered command count.
REQ-014 Port starve  output  1  request outstanding at least TIMEOUT cycles without grant.

Function
REQ-015 The block SHALL be the client end of the arbiter: it buffers commands, raises req while any are buffered, and issues one command per granted cycle.
REQ-016 Buffer SHALL be a DEPTH-entry FIFO with wrapping read/write pointers and a count register driving pending.
REQ-017 cmd_ready SHALL equal (pending < DEPTH), combinationally from count; push occurs on a clock edge where cmd_valid && cmd_ready.
REQ-018 req SHALL equal (pending != 0); it rises the cycle after the first push into an empty buffer (no bypass).
REQ-019 A pop SHALL occur on a clock edge where req && grant; grant while req is 0 SHALL be ignored.
REQ-020 After a pop at edge m, out_valid SHALL be 1 and out_data SHALL be the popped head for the cycle following m; otherwise out_valid is 0 and out_data holds its last value.
REQ-021 Back-to-back grants SHALL pop one entry per cycle, giving consecutive out_valid pulses in FIFO order.
REQ-022 Simultaneous push and pop SHALL leave pending unchanged; when full, cmd_ready is 0, so no push occurs even if a pop happens that edge.
REQ-023 State machine SHALL be IDLE (pending==0), WAIT (req high, wait_cnt < TIMEOUT), STARVE (req high, wait_cnt == TIMEOUT).
REQ-024 wait_cnt SHALL increment on each edge with req && !grant, saturate at TIMEOUT, and clear on any pop or when req is 0.
REQ-025 WAIT->STARVE on the edge wait_cnt reaches TIMEOUT; starve SHALL be 1 exactly in STARVE; any pop returns to WAIT (or IDLE if buffer empties).
REQ-026 IDLE->WAIT on the push into empty buffer; WAIT->IDLE on the pop of the last entry.

Reset
REQ-027 While rst_n is 0, regardless of clk: pointers, count, wait_cnt cleared; state IDLE; req, out_valid, starve 0; out_data 0; cmd_ready 1.
REQ-028 Reset asserted mid-operation SHALL discard all buffered commands; no out_valid pulse SHALL follow deassertion.

Verification
REQ-029 Push 0xA1 into empty agent, grant held 0 -> req 1 the next cycle, pending 1, cmd_ready 1.
REQ-030 Push 0x11,0x22,0x33,0x44, then grant 4 cycles -> out_valid pulses with 0x11,0x22,0x33,0x44 in order; req 0 and pending 0 afterwards.
REQ-031 Fill to DEPTH=4, hold cmd_valid with grant 1 for one cycle -> cmd_ready 0 at the full edge, so that edge pops only: pending 3; the next edge pushes, pending 4.
REQ-032 One entry buffered, grant 0 for 15 cycles -> starve 1 from cycle 15; grant pulse -> out_valid next cycle, starve 0, state IDLE.
REQ-033 Grant 1 with empty buffer -> no out_valid, pending stays 0.
REQ-034 Three entries buffered, rst_n pulsed low between edges -> req, pending, out_valid 0 immediately; no issue after release.
